// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths and FSM state type for the SPI bridge
package spi_pkg;
    localparam int BYTE_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - 2-flop synchronizer with registered rise/fall flags
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] stg;

    // Flags are registered alongside the last stage, so they coincide with the new synced value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg  <= {SYNC_STAGES{RST_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            stg  <= {stg[SYNC_STAGES-2:0], din};
            rise <= stg[SYNC_STAGES-2] & ~stg[SYNC_STAGES-1];
            fall <= ~stg[SYNC_STAGES-2] & stg[SYNC_STAGES-1];
        end
    end
endmodule

// File: rtl/spi_bridge.sv
// rtl/spi_bridge.sv - SPI mode-0 slave to byte interface; SPI_MISO_HIZ_EN tri-states idle miso
module spi_bridge
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              byte_sync,
    output logic [BYTE_W-1:0] data_in,
    input  logic [BYTE_W-1:0] data_out
);
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_stg;
    logic                   mosi_s;
    state_t                 state, state_next;
    logic [2:0]             bit_cnt;
    logic [BYTE_W-2:0]      rx_shift;
    logic [BYTE_W-1:0]      rx_next;
    logic [BYTE_W-1:0]      tx_shift;
    logic                   reload;

    spi_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) mosi_stg <= '0;
        else        mosi_stg <= {mosi_stg[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s  = mosi_stg[SYNC_STAGES-1];
    assign rx_next = {rx_shift, mosi_s};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            data_in   <= '0;
            byte_sync <= 1'b0;
            reload    <= 1'b0;
        end else begin
            byte_sync <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt  <= '0;
                    tx_shift <= data_out;
                    reload   <= 1'b0;
                end
            end else if (cs_rise) begin
                // A partial byte is simply dropped; the next frame restarts at bit 0
                bit_cnt <= '0;
                reload  <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next[BYTE_W-2:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(BYTE_W - 1)) begin
                        data_in   <= rx_next;
                        byte_sync <= 1'b1;
                        reload    <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (reload) begin
                        tx_shift <= data_out;
                        reload   <= 1'b0;
                    end else begin
                        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

`ifdef SPI_MISO_HIZ_EN
    assign miso = (rst_n && state == SHIFT) ? tx_shift[BYTE_W-1] : 1'bz;
`else
    assign miso = (rst_n && state == SHIFT) ? tx_shift[BYTE_W-1] : 1'b0;
`endif
endmodule

// File: tb/tb_spi_bridge.sv
// tb/tb_spi_bridge.sv - randomized self-checking bench for spi_bridge against a byte-level model
module tb_spi_bridge;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] data_out = 8'h00;
    wire        miso;
    logic       byte_sync;
    logic [7:0] data_in;

    spi_bridge dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .byte_sync(byte_sync),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    bit run_cmp = 0;

    typedef struct {
        int         at;
        logic [7:0] data;
    } ev_t;
    ev_t        expq[$];
    logic [7:0] exp_data = 8'h00;

    logic [7:0] tx_b[8];
    logic [7:0] dout_b[8];

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic chk_idle_miso(input string name);
        checks++;
`ifdef SPI_MISO_HIZ_EN
        if (miso !== 1'bz) begin
            errors++;
            $display("FAIL %s got=%b exp=z", name, miso);
        end
`else
        if (miso !== 1'b0) begin
            errors++;
            $display("FAIL %s got=%b exp=0", name, miso);
        end
`endif
    endtask

    // Model: each completed byte must appear on data_in with byte_sync exactly 3 clk after its 8th rise
    always @(negedge clk) begin
        logic exp_sync;
        if (run_cmp) begin
            exp_sync = 1'b0;
            if (!rst_q) begin
                expq.delete();
                exp_data = 8'h00;
            end else if (expq.size() > 0 && expq[0].at == cyc) begin
                exp_sync = 1'b1;
                exp_data = expq[0].data;
                void'(expq.pop_front());
            end
            checks++;
            if (byte_sync !== exp_sync) begin
                errors++;
                $display("FAIL byte_sync cyc=%0d got=%b exp=%b", cyc, byte_sync, exp_sync);
            end
            checks++;
            if (data_in !== exp_data) begin
                errors++;
                $display("FAIL data_in cyc=%0d got=%h exp=%h", cyc, data_in, exp_data);
            end
            if (byte_sync === 1'b1) pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Master side of one byte; nd is presented on data_out dd clk after the 8th rise
    task automatic send_byte(input logic [7:0] tx, input int half, input int nbits,
                             input logic [7:0] nd, input int dd, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            tick(half);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            if (i == 7) begin
                expq.push_back('{at: cyc + 3, data: tx});
                tick(dd);
                data_out = nd;
                tick(half - dd);
            end else begin
                tick(half);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nb, input int half);
        logic [7:0] rx;
        data_out = dout_b[0];
        tick(2);
        cs_n = 1'b0;
        tick(4);
        for (int n = 0; n < nb; n++) begin
            send_byte(tx_b[n], half, 8, (n + 1 < nb) ? dout_b[n+1] : dout_b[n], 0, rx);
            chk8("miso_byte", rx, dout_b[n]);
        end
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic partial(input logic [7:0] tx, input int nbits, input int half);
        logic [7:0] rx;
        cs_n = 1'b0;
        tick(4);
        send_byte(tx, half, nbits, data_out, 0, rx);
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [7:0] rx;
        int p0, nb, half;

        rst_n = 1'b0;
        tick(3);
        chk8("reset_data_in", data_in, 8'h00);
        chk8("reset_byte_sync", {7'd0, byte_sync}, 8'h00);
        chk_idle_miso("reset_miso");
        rst_n = 1'b1;
        run_cmp = 1;
        tick(4);

        // two bytes in one frame
        tx_b[0] = 8'h93; tx_b[1] = 8'hA6; dout_b[0] = 8'h00; dout_b[1] = 8'h00;
        p0 = pulses;
        run_frame(2, 4);
        chk_int("two_byte_pulses", pulses - p0, 2);
        chk8("two_byte_last", data_in, 8'hA6);

        // response loaded one clk after byte_sync goes out in the next byte
        data_out = 8'h3C;
        tick(2);
        cs_n = 1'b0;
        tick(4);
        send_byte(8'h20, 4, 8, 8'hAB, 4, rx);
        chk8("resp_first_byte", rx, 8'h3C);
        send_byte(8'h00, 4, 8, 8'hAB, 0, rx);
        chk8("resp_second_byte", rx, 8'hAB);
        tick(4);
        cs_n = 1'b1;
        tick(8);
        chk_idle_miso("idle_miso");

        // cs_n abort after 5 bits, then a clean byte
        p0 = pulses;
        partial(8'hFF, 5, 4);
        chk_int("abort_no_pulse", pulses - p0, 0);
        tx_b[0] = 8'h5A; dout_b[0] = 8'h11;
        run_frame(1, 4);
        chk_int("abort_then_one", pulses - p0, 1);
        chk8("abort_then_data", data_in, 8'h5A);

        // reset pulse mid-byte
        p0 = pulses;
        cs_n = 1'b0;
        tick(4);
        send_byte(8'hC3, 4, 3, data_out, 0, rx);
        rst_n = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk_int("rst_no_pulse", pulses - p0, 0);
        chk8("rst_data_in", data_in, 8'h00);
        tx_b[0] = 8'h81; dout_b[0] = 8'h7E;
        run_frame(1, 4);
        chk8("rst_then_data", data_in, 8'h81);

        // four back-to-back bytes
        for (int i = 0; i < 4; i++) begin
            tx_b[i]   = 8'h80 + 8'(i);
            dout_b[i] = 8'(8'hC0 + 8'(i));
        end
        p0 = pulses;
        run_frame(4, 4);
        chk_int("b2b_pulses", pulses - p0, 4);
        chk8("b2b_last", data_in, 8'h83);

        // randomized frames with occasional aborted prefixes
        for (int f = 0; f < 30; f++) begin
            half = $urandom_range(4, 6);
            nb   = $urandom_range(1, 4);
            if ($urandom_range(0, 4) == 0)
                partial(8'($urandom), $urandom_range(1, 7), half);
            for (int n = 0; n < nb; n++) begin
                tx_b[n]   = 8'($urandom);
                dout_b[n] = 8'($urandom);
            end
            p0 = pulses;
            run_frame(nb, half);
            chk_int("rand_pulses", pulses - p0, nb);
        end

        tick(10);
        chk_int("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_bridge.md
SPI_BRIDGE -- requirements
Module: spi_bridge

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, sampled only on the rising edge of clk.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 sclk  input  1  SPI serial clock, asynchronous to clk, at most clk/8.
REQ-005 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-006 mosi  input  1  SPI master-out data, asynchronous.
REQ-007 miso  output  1  SPI master-in data.
REQ-008 byte_sync  output  1  single-clk pulse; data_in is valid while it is high.
REQ-009 data_in  output  8  last complete received byte, delivered to instr_dcd.
REQ-010 data_out  input  8  byte from instr_dcd to transmit in the next byte slot.

Function
REQ-011 Each of sclk, cs_n and mosi SHALL pass through a 2-flop synchronizer before use.
REQ-012 The SPI protocol SHALL be mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
REQ-013 An sclk rising edge SHALL be detected as synced sclk 1 with the previous synced value 0; a falling edge is the reverse.
REQ-014 The FSM SHALL have two states, IDLE (cs_n high) and SHIFT (cs_n low).
REQ-015 IDLE→SHIFT SHALL occur on synced cs_n falling; SHIFT→IDLE on synced cs_n rising.
REQ-016 On entry to SHIFT: bit_cnt SHALL be 0, tx_shift SHALL be loaded from data_out, and miso SHALL drive data_out[7].
REQ-017 On each rising edge in SHIFT, synced mosi SHALL shift into the rx_shift LSB and bit_cnt SHALL increment modulo 8.
REQ-018 On the rising edge where bit_cnt wraps 7→0, the full byte SHALL be registered into data_in and byte_sync pulsed high for exactly one clk in the following cycle.
REQ-019 Latency SHALL be fixed: byte_sync high 3 clk cycles after the 8th sclk rising edge reaches the pins.
REQ-020 data_in SHALL hold its value until the next completed byte.
REQ-021 On each falling edge in SHIFT, tx_shift SHALL shift left and miso SHALL present the next bit.
REQ-022 On the falling edge that follows a byte completion, tx_shift SHALL reload from data_out, so the decoder response is sent in the next byte.
REQ-023 Back-to-back bytes within one cs_n frame SHALL be supported without gaps.
REQ-024 cs_n deassert mid-byte (bit_cnt≠0) SHALL discard the partial byte, produce no byte_sync, and reset bit_cnt to 0.
REQ-025 sclk edges seen while in IDLE SHALL be ignored.

Reset
REQ-026 On rst_n low at a clk edge, all of the following SHALL take their reset values: state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=0, data_in=8'h00, byte_sync=0, all synchronizer flops set to their idle levels (sclk 0, cs_n 1, mosi 0).
REQ-027 miso SHALL take its idle value (REQ-029) during reset.
REQ-028 Reset asserted mid-byte SHALL abort the byte with no byte_sync; after release, the block SHALL wait for a fresh cs_n falling edge.

Configuration
REQ-029 With SPI_MISO_HIZ_EN defined, miso SHALL be 1'bz whenever the state is IDLE or during reset; without it, miso SHALL drive 1'b0 in those conditions.

Structure
REQ-030 Package spi_pkg SHALL hold BYTE_W=8, SYNC_STAGES=2 and the FSM state enum (IDLE, SHIFT).
REQ-031 One sub-module, spi_sync, SHALL implement a 2-flop synchronizer with registered rise/fall flags, instantiated for sclk and cs_n (mosi uses the synchronizer only).

Verification
REQ-032 One cs_n frame sending 0x93 then 0xA6 at clk/8 -> two byte_sync pulses, with data_in 0x93 then 0xA6.
REQ-033 Send 0x20, with data_out set to 0xAB one clk after the first byte_sync, then send 0x00 -> the second byte on miso is 0xAB, MSB first.
REQ-034 cs_n raised after 5 bits of 0xFF, then a new frame with 0x5A -> no byte_sync for the partial byte, then exactly one byte_sync with data_in=0x5A.
REQ-035 rst_n pulsed low for 1 clk mid-byte -> byte_sync stays 0, data_in=0x00; the next full frame with 0x81 is received correctly.
REQ-036 cs_n high with SPI_MISO_HIZ_EN defined -> miso=z; rebuilt without the macro -> miso=0.
REQ-037 Four back-to-back bytes 0x80..0x83 in one frame -> four byte_sync pulses, each 3 clk after its 8th sclk rising edge.
